// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares the 8-digit hex seven-segment display between three requesters
//   (0 = fault/status, 1 = debug word, 2 = user/monitor word). One owner at
//   a time, with a guaranteed minimum dwell, urgent preemption by requester 0
//   and per-owner blinking.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   req[2:0]   level request per requester
//   blink[2:0] per-requester blink enable, honoured while granted
//   data0..2   32-bit hex words, nibble 0 = rightmost digit
//   grant      one-hot owner, 3'b000 = idle
//   grant_ack  one-cycle pulse when a new non-idle owner is granted
//   disp_data  word to the display scan driver
//   digit_en   per-digit enable, 1 = lit
//   busy       grant != 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nobody granted, DEFAULT_DATA shown, all digits lit
// SHOW  | owner granted, dwell counting up toward DWELL_CYCLES-1
// OPEN  | dwell met, owner may be replaced or released every cycle
module seg_display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 5_000_000,
    parameter int unsigned BLINK_CYCLES = 2_500_000,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  blink,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  grant,
    output logic        grant_ack,
    output logic [31:0] disp_data,
    output logic [7:0]  digit_en,
    output logic        busy
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, OPEN} state_t;

    state_t        state;
    logic [1:0]    owner_idx;
    logic [1:0]    rr_ptr;
    logic [DW-1:0] dwell_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Round-robin pick: first set bit of m scanning upward from p+1 (mod 3).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] m, input logic [1:0] p);
        logic [1:0] i0, i1, i2;
        i0 = (p == 2'd2) ? 2'd0 : p + 2'd1;
        i1 = (i0 == 2'd2) ? 2'd0 : i0 + 2'd1;
        i2 = (i1 == 2'd2) ? 2'd0 : i1 + 2'd1;
        if (m[i0]) return {1'b1, i0};
        if (m[i1]) return {1'b1, i1};
        if (m[i2]) return {1'b1, i2};
        return 3'b000;
    endfunction

    function automatic logic [31:0] sel_data(input logic [1:0] idx,
                                             input logic [31:0] d0,
                                             input logic [31:0] d1,
                                             input logic [31:0] d2);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    logic [2:0]  pick_all, pick_oth;
    logic        preempt, dwell_done, blink_wrap, next_phase;
    logic        owner_req, owner_blink;
    logic        take, go_idle;
    logic [1:0]  take_idx;
    logic [31:0] take_data, owner_data;

    always_comb begin
        pick_all    = rr_pick(req, rr_ptr);
        pick_oth    = rr_pick(req & ~grant, rr_ptr);
        preempt     = req[0] && (grant[1] || grant[2]);
        dwell_done  = (dwell_cnt == DWELL_LAST);
        blink_wrap  = (blink_cnt == BLINK_LAST);
        next_phase  = blink_wrap ? ~blink_phase : blink_phase;
        owner_req   = 1'b0;
        owner_blink = 1'b0;
        case (owner_idx)
            2'd0:    begin owner_req = req[0]; owner_blink = blink[0]; end
            2'd1:    begin owner_req = req[1]; owner_blink = blink[1]; end
            2'd2:    begin owner_req = req[2]; owner_blink = blink[2]; end
            default: begin owner_req = 1'b0;   owner_blink = 1'b0;     end
        endcase
        owner_data = sel_data(owner_idx, data0, data1, data2);

        take     = 1'b0;
        take_idx = 2'd0;
        go_idle  = 1'b0;
        case (state)
            IDLE: begin
                take     = pick_all[2];
                take_idx = pick_all[1:0];
            end
            default: begin
                if (preempt) begin
                    take     = 1'b1;
                    take_idx = 2'd0;
                end else if (state == OPEN && pick_oth[2]) begin
                    take     = 1'b1;
                    take_idx = pick_oth[1:0];
                end else if (state == OPEN && !owner_req) begin
                    go_idle = 1'b1;
                end else if (state == SHOW && dwell_done && req == 3'b000) begin
                    // Dwell expires with nobody asking: release directly.
                    go_idle = 1'b1;
                end
            end
        endcase
        take_data = sel_data(take_idx, data0, data1, data2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_idx   <= 2'd0;
            rr_ptr      <= 2'd2;
            dwell_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            grant       <= 3'b000;
            grant_ack   <= 1'b0;
            disp_data   <= DEFAULT_DATA;
            digit_en    <= 8'hFF;
            busy        <= 1'b0;
        end else begin
            grant_ack <= 1'b0;
            if (take) begin
                state       <= SHOW;
                owner_idx   <= take_idx;
                rr_ptr      <= take_idx;
                grant       <= 3'b001 << take_idx;
                grant_ack   <= 1'b1;
                busy        <= 1'b1;
                dwell_cnt   <= '0;
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
                disp_data   <= take_data;
                digit_en    <= 8'hFF;
            end else if (go_idle || state == IDLE) begin
                state       <= IDLE;
                grant       <= 3'b000;
                busy        <= 1'b0;
                dwell_cnt   <= '0;
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
                disp_data   <= DEFAULT_DATA;
                digit_en    <= 8'hFF;
            end else begin
                if (state == SHOW) begin
                    if (dwell_done)
                        state <= OPEN;
                    else
                        dwell_cnt <= dwell_cnt + 1'b1;
                end
                // Live tracking while the owner still asks; frozen otherwise.
                if (owner_req)
                    disp_data <= owner_data;
                blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
                blink_phase <= next_phase;
                // Use the upcoming phase so digit_en lines up with the counter.
                digit_en    <= (owner_blink && next_phase) ? 8'h00 : 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  blink;
    logic [31:0] data0, data1, data2;
    logic [2:0]  grant;
    logic        grant_ack;
    logic [31:0] disp_data;
    logic [7:0]  digit_en;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    seg_display_arbiter #(
        .DWELL_CYCLES(8),
        .BLINK_CYCLES(4),
        .DEFAULT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .blink(blink),
        .data0(data0), .data1(data1), .data2(data2),
        .grant(grant), .grant_ack(grant_ack), .disp_data(disp_data),
        .digit_en(digit_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, {29'd0, grant}, 32'd0);
        chk({tag, "_ack"},   {31'd0, grant_ack}, 32'd0);
        chk({tag, "_data"},  disp_data, 32'hDEAD_BEEF);
        chk({tag, "_den"},   {24'd0, digit_en}, 32'hFF);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; blink = 3'b000;
        data0 = 32'h0; data1 = 32'h0; data2 = 32'h0;
        step(3);
        rst = 1'b0;
        chk_idle("rst");
        step(2);
        chk_idle("idle");

        // Single request from requester 1 (rr_ptr=2 -> scan 0,1,2)
        req = 3'b010; data1 = 32'h0012_3456;
        step(1);                                        // t+1
        chk("s_grant", {29'd0, grant}, 32'h2);
        chk("s_ack",   {31'd0, grant_ack}, 32'h1);
        chk("s_data",  disp_data, 32'h0012_3456);
        chk("s_busy",  {31'd0, busy}, 32'h1);
        data1 = 32'h0000_0001;
        step(1);                                        // t+2
        chk("s_ack_pulse", {31'd0, grant_ack}, 32'h0);
        chk("s_track", disp_data, 32'h0000_0001);
        step(1);                                        // t+3
        req = 3'b000; data1 = 32'hAAAA_AAAA;
        step(5);                                        // t+8
        chk("s_hold",   {29'd0, grant}, 32'h2);
        chk("s_frozen", disp_data, 32'h0000_0001);
        step(1);                                        // t+9
        chk_idle("s_rel");

        // Round robin with req=110 (rr_ptr=1 -> requester 2 first)
        data1 = 32'h1111_1111; data2 = 32'h2222_2222;
        req = 3'b110;
        step(1);                                        // t+1
        chk("rr_g0",   {29'd0, grant}, 32'h4);
        chk("rr_ack0", {31'd0, grant_ack}, 32'h1);
        chk("rr_d0",   disp_data, 32'h2222_2222);
        step(8);                                        // t+9, still owner 2
        chk("rr_hold0", {29'd0, grant}, 32'h4);
        chk("rr_noack", {31'd0, grant_ack}, 32'h0);
        step(1);                                        // t+10
        chk("rr_g1",   {29'd0, grant}, 32'h2);
        chk("rr_ack1", {31'd0, grant_ack}, 32'h1);
        chk("rr_d1",   disp_data, 32'h1111_1111);
        step(8);                                        // t+18
        chk("rr_hold1", {29'd0, grant}, 32'h2);
        step(1);                                        // t+19
        chk("rr_g2",   {29'd0, grant}, 32'h4);
        chk("rr_ack2", {31'd0, grant_ack}, 32'h1);

        // Preemption at dwell_cnt=3 of owner 2
        req = 3'b100;
        step(3);                                        // dwell_cnt=3
        chk("p_pre", {29'd0, grant}, 32'h4);
        req = 3'b101; data0 = 32'h0000_00F0;
        step(1);
        chk("p_grant", {29'd0, grant}, 32'h1);
        chk("p_ack",   {31'd0, grant_ack}, 32'h1);
        chk("p_data",  disp_data, 32'h0000_00F0);
        step(8);                                        // requester 0 dwell + OPEN
        chk("p_hold0", {29'd0, grant}, 32'h1);
        step(1);
        chk("p_back",  {29'd0, grant}, 32'h4);
        chk("p_back_ack", {31'd0, grant_ack}, 32'h1);
        chk("p_back_d", disp_data, 32'h2222_2222);

        // Asynchronous reset mid-SHOW
        req = 3'b000;
        step(1);
        rst = 1'b1;
        #1;
        chk_idle("arst");
        step(1);
        rst = 1'b0;
        step(1);
        chk_idle("arst_rel");

        // Blink, owner 1 (rr_ptr=2 after reset)
        req = 3'b010; blink = 3'b010;
        step(1);                                        // t+1
        chk("b_grant", {29'd0, grant}, 32'h2);
        chk("b_d1", {24'd0, digit_en}, 32'hFF);
        step(3);                                        // t+4
        chk("b_d4", {24'd0, digit_en}, 32'hFF);
        step(1);                                        // t+5
        chk("b_d5", {24'd0, digit_en}, 32'h00);
        step(3);                                        // t+8
        chk("b_d8", {24'd0, digit_en}, 32'h00);
        step(1);                                        // t+9
        chk("b_d9", {24'd0, digit_en}, 32'hFF);
        step(4);                                        // t+13
        chk("b_d13", {24'd0, digit_en}, 32'h00);
        blink = 3'b000;
        step(1);                                        // t+14
        chk("b_clear", {24'd0, digit_en}, 32'hFF);
        req = 3'b110; blink = 3'b110;
        step(1);                                        // owner switch
        chk("b_sw_grant", {29'd0, grant}, 32'h4);
        chk("b_sw_d0", {24'd0, digit_en}, 32'hFF);
        step(3);
        chk("b_sw_d3", {24'd0, digit_en}, 32'hFF);
        step(1);
        chk("b_sw_d4", {24'd0, digit_en}, 32'h00);
        req = 3'b000; blink = 3'b000;                   // owner 2 at dwell_cnt=4
        step(4);
        chk_idle("b_rel");

        // Owner alone in OPEN (rr_ptr=2 -> requester 0)
        req = 3'b001; data0 = 32'h0BAD_F00D;
        step(1);
        chk("o_grant", {29'd0, grant}, 32'h1);
        chk("o_ack",   {31'd0, grant_ack}, 32'h1);
        for (int i = 0; i < 29; i++) begin
            step(1);
            chk("o_loop_grant", {29'd0, grant}, 32'h1);
            chk("o_loop_ack",   {31'd0, grant_ack}, 32'h0);
        end
        chk("o_data", disp_data, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
